// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: PC feedback, instruction-memory read port,
// decode handshake and branch redirect. The master side is the sequencer;
// the slave side is the surrounding core (PC register, memory, decode).
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    // Program counter loop
    logic [DATA_WIDTH-1:0]  pc_cur;
    logic [DATA_WIDTH-1:0]  pc_next;

    // Instruction memory read port
    logic                   fetch_en;
    logic                   mem_req;
    logic [DATA_WIDTH-1:0]  mem_addr;
    logic                   mem_rvalid;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    // Decode handshake
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;

    // Branch redirect
    logic                   redirect;
    logic [DATA_WIDTH-1:0]  redirect_pc;

    modport master (
        input  pc_cur, fetch_en, mem_rvalid, mem_rdata, instr_ready,
               redirect, redirect_pc,
        output pc_next, mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output pc_cur, fetch_en, mem_rvalid, mem_rdata, instr_ready,
               redirect, redirect_pc,
        input  pc_next, mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer. Drives the next PC back into the program
// counter every cycle (the PC has no enable, so "hold" is pc_next = pc_cur),
// issues one outstanding instruction-memory read at a time, buffers the
// returned word for decode and handles branch redirects, including dropping
// the response of a fetch that was in flight when the redirect arrived.
// Optional build macro FETCH_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles in which decode refused a valid instruction.
module fetch_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    // ISSUE: may send a request. WAIT: request outstanding, response wanted.
    // HOLD: instruction buffered for decode. DRAIN: request outstanding but
    // its response belongs to a discarded fetch (this state is the discard flag).
    localparam logic [1:0] ISSUE = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0]  instr_pc_q;
    logic [DATA_WIDTH-1:0]  pc_next_d;
    logic                   mem_req_d;
    logic                   capture;

    // Next-state, next-PC and request decode; redirect outranks every other event
    always_comb begin
        state_d   = state_q;
        pc_next_d = bus.pc_cur;
        mem_req_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ISSUE: begin
                if (bus.redirect) begin
                    pc_next_d = bus.redirect_pc;
                end else if (bus.fetch_en) begin
                    mem_req_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    pc_next_d = bus.redirect_pc;
                    state_d   = bus.mem_rvalid ? ISSUE : DRAIN;
                end else if (bus.mem_rvalid) begin
                    capture   = 1'b1;
                    pc_next_d = bus.pc_cur + DATA_WIDTH'(1);
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_next_d = bus.redirect_pc;
                    state_d   = ISSUE;
                end else if (valid_q && bus.instr_ready) begin
                    state_d   = ISSUE;
                end
            end
            DRAIN: begin
                if (bus.redirect) begin
                    pc_next_d = bus.redirect_pc;
                end
                if (bus.mem_rvalid) begin
                    state_d   = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    // While reset is held the PC is pinned to zero and no request may leave
    assign bus.pc_next     = rst ? '0 : pc_next_d;
    assign bus.mem_req     = ~rst & mem_req_d;
    assign bus.mem_addr    = bus.pc_cur;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode buffer: valid exactly while holding, payload loaded on an accepted response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            valid_q <= (state_d == HOLD);
            if (capture) begin
                instr_q    <= bus.mem_rdata;
                instr_pc_q <= bus.pc_cur;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Decode backpressure counter, saturating and restarted by each redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bus.redirect) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !bus.instr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Models the program counter register and a
// single-outstanding instruction memory returning {8'h00, addr}. Expected
// decode transfers {instr_pc, instr} are queued by each scenario and popped
// when decode accepts an instruction.
module tb_fetch_sequencer;

    localparam int DW = 8;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [DW+IW-1:0] expQ[$];

    int          reqCount   = 0;
    int          memLatency = 1;
    logic        pending    = 1'b0;
    int          pendCnt    = 0;
    logic [DW-1:0] pendAddr = '0;

    fetch_sequencer_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus();

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stallCnt;
`endif

    fetch_sequencer #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o (stallCnt)
`endif
    );

    always #5 clk = ~clk;

    // Program counter register: loads pc_next every cycle, async reset to zero
    always @(posedge clk or posedge rst) begin
        if (rst) bus.pc_cur <= '0;
        else     bus.pc_cur <= bus.pc_next;
    end

    // Negedge sampling: record memory requests and score decode transfers
    task automatic sampleCycle();
        logic [DW+IW-1:0] got;
        logic [DW+IW-1:0] exp;
        @(negedge clk);
        if (!rst && bus.mem_req) begin
            checks++;
            if (pending) begin
                failures++;
                $display("[TB] FAIL single_outstanding: outstanding=2 at addr %h, required at most 1", bus.mem_addr);
            end
            pending  = 1'b1;
            pendCnt  = memLatency;
            pendAddr = bus.mem_addr;
            reqCount++;
        end
        if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            checks++;
            got = {bus.instr_pc, bus.instr};
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_instr: got %h, required no transfer", got);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL scoreboard: got {pc,instr}=%h, required %h", got, exp);
                end
            end
        end
    endtask

    // Step to just after the next rising edge and drive the memory response
    task automatic advance();
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'hDEAD;
        if (pending) begin
            if (pendCnt <= 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = {8'h00, pendAddr};
                pending        = 1'b0;
            end else begin
                pendCnt--;
            end
        end
    endtask

    // Run until the scoreboard drains; fetch_en drops once a request leaves
    task automatic runUntilEmpty(input int maxCycles);
        int startReq;
        startReq = reqCount;
        for (int n = 0; n < maxCycles && expQ.size() != 0; n++) begin
            sampleCycle();
            advance();
            if (reqCount > startReq) bus.fetch_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        bus.fetch_en = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.instr_valid); end
        if (bus.instr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_instr: got %h, required 0000", bus.instr); end
        if (bus.instr_pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_instr_pc: got %h, required 00", bus.instr_pc); end
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc_next: got %h, required 00", bus.pc_next); end
`ifdef FETCH_STALL_CNT_EN
        checks++;
        if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_stall_cnt: got %0d, required 0", stallCnt); end
`endif
        @(posedge clk);
        #1;
        bus.fetch_en = 1'b0;
        rst = 1'b0;
        sampleCycle();
        checks += 2;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL idle_mem_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h00) begin failures++; $display("[TB] FAIL idle_pc_hold: got %h, required 00", bus.pc_next); end
        advance();
    endtask

    task automatic test_linear_fetch();
        int startReq;
        int cyc;
        logic [DW-1:0] expAddr;
        logic [DW-1:0] expNext;
        startReq = reqCount;
        cyc      = 0;
        expAddr  = 8'h00;
        for (int i = 0; i < 4; i++) expQ.push_back({8'(i), 16'(i)});
        bus.instr_ready = 1'b1;
        bus.fetch_en    = 1'b1;
        for (int n = 1; n <= 40 && cyc == 0; n++) begin
            sampleCycle();
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_addr !== expAddr) begin failures++; $display("[TB] FAIL linear_addr: got %h, required %h", bus.mem_addr, expAddr); end
                expAddr = expAddr + 8'd1;
            end
            expNext = bus.mem_rvalid ? bus.pc_cur + 8'd1 : bus.pc_cur;
            checks++;
            if (bus.pc_next !== expNext) begin failures++; $display("[TB] FAIL linear_pc_next: got %h, required %h", bus.pc_next, expNext); end
            if (expQ.size() == 0) cyc = n;
            advance();
            if (reqCount - startReq >= 4) bus.fetch_en = 1'b0;
        end
        checks += 4;
        if (cyc !== 12) begin failures++; $display("[TB] FAIL linear_throughput: got %0d cycles, required 12", cyc); end
        if (reqCount - startReq !== 4) begin failures++; $display("[TB] FAIL linear_req_count: got %0d, required 4", reqCount - startReq); end
        if (bus.pc_cur !== 8'h04) begin failures++; $display("[TB] FAIL linear_pc_end: got %h, required 04", bus.pc_cur); end
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL linear_no_extra_req: got %b, required 0", bus.mem_req); end
    endtask

    task automatic test_backpressure();
        int startReq;
        logic got;
        startReq = reqCount;
        got = 1'b0;
        bus.instr_ready = 1'b0;
        bus.fetch_en    = 1'b1;
        expQ.push_back({8'h04, 16'h0004});
        for (int n = 0; n < 10 && !got; n++) begin
            sampleCycle();
            if (bus.instr_valid) got = 1'b1;
            else begin
                advance();
                if (reqCount > startReq) bus.fetch_en = 1'b0;
            end
        end
        checks++;
        if (got !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_timeout: got valid=0, required 1"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) sampleCycle();
            checks += 5;
            if (bus.instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d]: got %b, required 1", i, bus.instr_valid); end
            if (bus.instr !== 16'h0004) begin failures++; $display("[TB] FAIL bp_instr[%0d]: got %h, required 0004", i, bus.instr); end
            if (bus.instr_pc !== 8'h04) begin failures++; $display("[TB] FAIL bp_instr_pc[%0d]: got %h, required 04", i, bus.instr_pc); end
            if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_mem_req[%0d]: got %b, required 0", i, bus.mem_req); end
            if (bus.pc_next !== bus.pc_cur) begin failures++; $display("[TB] FAIL bp_pc_hold[%0d]: got %h, required %h", i, bus.pc_next, bus.pc_cur); end
            advance();
        end
`ifdef FETCH_STALL_CNT_EN
        checks++;
        if (stallCnt !== 16'd5) begin failures++; $display("[TB] FAIL bp_stall_cnt: got %0d, required 5", stallCnt); end
`endif
        bus.instr_ready = 1'b1;
        runUntilEmpty(10);
        checks += 2;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL bp_drain: got %0d pending, required 0", expQ.size()); end
        if (bus.pc_cur !== 8'h05) begin failures++; $display("[TB] FAIL bp_pc_end: got %h, required 05", bus.pc_cur); end
    endtask

    task automatic test_redirect_wait();
        bus.instr_ready = 1'b1;
        memLatency      = 3;
        bus.fetch_en    = 1'b1;
        sampleCycle();
        checks += 2;
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rw_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'h05) begin failures++; $display("[TB] FAIL rw_addr: got %h, required 05", bus.mem_addr); end
        advance();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        sampleCycle();
        checks += 2;
        if (bus.pc_next !== 8'h40) begin failures++; $display("[TB] FAIL rw_pc_next: got %h, required 40", bus.pc_next); end
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rw_wait_req: got %b, required 0", bus.mem_req); end
        advance();
        bus.redirect = 1'b0;
`ifdef FETCH_STALL_CNT_EN
        checks++;
        if (stallCnt !== 16'd0) begin failures++; $display("[TB] FAIL rw_stall_clear: got %0d, required 0", stallCnt); end
`endif
        sampleCycle();
        checks += 3;
        if (bus.pc_cur !== 8'h40) begin failures++; $display("[TB] FAIL rw_pc_cur: got %h, required 40", bus.pc_cur); end
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rw_drain_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h40) begin failures++; $display("[TB] FAIL rw_drain_hold: got %h, required 40", bus.pc_next); end
        advance();
        sampleCycle();
        checks += 3;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rw_drop_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h40) begin failures++; $display("[TB] FAIL rw_drop_pc: got %h, required 40", bus.pc_next); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rw_drop_valid: got %b, required 0", bus.instr_valid); end
        memLatency = 1;
        advance();
        sampleCycle();
        checks += 3;
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rw_resume_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'h40) begin failures++; $display("[TB] FAIL rw_resume_addr: got %h, required 40", bus.mem_addr); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rw_stale_valid: got %b, required 0", bus.instr_valid); end
        expQ.push_back({8'h40, 16'h0040});
        advance();
        bus.fetch_en = 1'b0;
        runUntilEmpty(10);
        checks += 2;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL rw_drain: got %0d pending, required 0", expQ.size()); end
        if (bus.pc_cur !== 8'h41) begin failures++; $display("[TB] FAIL rw_pc_end: got %h, required 41", bus.pc_cur); end
    endtask

    task automatic test_redirect_coincident();
        bus.instr_ready = 1'b1;
        memLatency      = 1;
        bus.fetch_en    = 1'b1;
        sampleCycle();
        checks++;
        if (bus.mem_addr !== 8'h41) begin failures++; $display("[TB] FAIL rc_addr: got %h, required 41", bus.mem_addr); end
        advance();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h60;
        sampleCycle();
        checks++;
        if (bus.pc_next !== 8'h60) begin failures++; $display("[TB] FAIL rc_pc_next: got %h, required 60", bus.pc_next); end
        advance();
        bus.redirect = 1'b0;
        sampleCycle();
        checks += 3;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rc_valid: got %b, required 0", bus.instr_valid); end
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rc_resume_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'h60) begin failures++; $display("[TB] FAIL rc_resume_addr: got %h, required 60", bus.mem_addr); end
        expQ.push_back({8'h60, 16'h0060});
        advance();
        bus.fetch_en = 1'b0;
        runUntilEmpty(10);
        checks++;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL rc_drain: got %0d pending, required 0", expQ.size()); end

        // Redirect in HOLD while decode is ready
        bus.fetch_en = 1'b1;
        sampleCycle();
        checks++;
        if (bus.mem_addr !== 8'h61) begin failures++; $display("[TB] FAIL rh_addr: got %h, required 61", bus.mem_addr); end
        advance();
        bus.fetch_en = 1'b0;
        sampleCycle();
        checks++;
        if (bus.pc_next !== 8'h62) begin failures++; $display("[TB] FAIL rh_pc_inc: got %h, required 62", bus.pc_next); end
        advance();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h80;
        bus.fetch_en    = 1'b1;
        sampleCycle();
        checks += 3;
        if (bus.instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL rh_hold_valid: got %b, required 1", bus.instr_valid); end
        if (bus.instr_pc !== 8'h61) begin failures++; $display("[TB] FAIL rh_hold_pc: got %h, required 61", bus.instr_pc); end
        if (bus.pc_next !== 8'h80) begin failures++; $display("[TB] FAIL rh_pc_next: got %h, required 80", bus.pc_next); end
        advance();
        bus.redirect = 1'b0;
        sampleCycle();
        checks += 3;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rh_valid: got %b, required 0", bus.instr_valid); end
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rh_resume_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'h80) begin failures++; $display("[TB] FAIL rh_resume_addr: got %h, required 80", bus.mem_addr); end
        expQ.push_back({8'h80, 16'h0080});
        advance();
        bus.fetch_en = 1'b0;
        runUntilEmpty(10);
        checks += 2;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL rh_drain: got %0d pending, required 0", expQ.size()); end
        if (bus.pc_cur !== 8'h81) begin failures++; $display("[TB] FAIL rh_pc_end: got %h, required 81", bus.pc_cur); end
    endtask

    task automatic test_wrap();
        bus.instr_ready = 1'b1;
        bus.fetch_en    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFF;
        sampleCycle();
        checks += 2;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL wrap_issue_redirect_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_redirect_pc: got %h, required FF", bus.pc_next); end
        advance();
        bus.redirect = 1'b0;
        sampleCycle();
        checks += 2;
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL wrap_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_addr: got %h, required FF", bus.mem_addr); end
        expQ.push_back({8'hFF, 16'h00FF});
        advance();
        bus.fetch_en = 1'b0;
        sampleCycle();
        checks++;
        if (bus.pc_next !== 8'h00) begin failures++; $display("[TB] FAIL wrap_pc_next: got %h, required 00", bus.pc_next); end
        advance();
        runUntilEmpty(10);
        checks += 2;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL wrap_drain: got %0d pending, required 0", expQ.size()); end
        if (bus.pc_cur !== 8'h00) begin failures++; $display("[TB] FAIL wrap_pc_end: got %h, required 00", bus.pc_cur); end
    endtask

    task automatic test_reset_wait();
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h23;
        sampleCycle();
        advance();
        bus.redirect = 1'b0;
        memLatency   = 3;
        bus.fetch_en = 1'b1;
        sampleCycle();
        checks++;
        if (bus.mem_addr !== 8'h23) begin failures++; $display("[TB] FAIL rst_pre_addr: got %h, required 23", bus.mem_addr); end
        advance();
        bus.fetch_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_valid: got %b, required 0", bus.instr_valid); end
        if (bus.instr_pc !== 8'h00) begin failures++; $display("[TB] FAIL rst_async_instr_pc: got %h, required 00", bus.instr_pc); end
        if (bus.instr !== 16'h0000) begin failures++; $display("[TB] FAIL rst_async_instr: got %h, required 0000", bus.instr); end
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h00) begin failures++; $display("[TB] FAIL rst_async_pc_next: got %h, required 00", bus.pc_next); end
        advance();
        rst = 1'b0;
        sampleCycle();
        checks++;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_idle_req: got %b, required 0", bus.mem_req); end
        advance();
        sampleCycle();
        checks += 2;
        if (bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_late_req: got %b, required 0", bus.mem_req); end
        if (bus.pc_next !== 8'h00) begin failures++; $display("[TB] FAIL rst_late_pc: got %h, required 00", bus.pc_next); end
        advance();
        memLatency   = 1;
        bus.fetch_en = 1'b1;
        sampleCycle();
        checks += 3;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_late_valid: got %b, required 0", bus.instr_valid); end
        if (bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rst_first_req: got %b, required 1", bus.mem_req); end
        if (bus.mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL rst_first_addr: got %h, required 00", bus.mem_addr); end
        expQ.push_back({8'h00, 16'h0000});
        advance();
        bus.fetch_en = 1'b0;
        runUntilEmpty(10);
        checks++;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL rst_drain: got %0d pending, required 0", expQ.size()); end
    endtask

    // Scenario sequence and summary
    initial begin
        rst             = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 16'hDEAD;
        test_reset();
        test_linear_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_wait();
        checks++;
        if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL final_queue: got %0d pending, required 0", expQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded 200000 time units, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
